// File: rtl/decode.sv
// Decode stage of the in-order RV32I pipeline.
// Registers one fetched instruction per cycle. It splits the instruction into
// register indices, a sign-extended immediate and control flags, and flags
// illegal encodings. Fetch-side exceptions override illegal-encoding detection.
module decode #(
    parameter int ADDR_W     = 32,
    parameter int INSTR_W    = 32,
    parameter int EX_W       = 4,
    parameter int EX_ILLEGAL = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] fe_instr,
    input  logic [ADDR_W-1:0]  fe_pc,
    input  logic [EX_W-1:0]    fe_exception,
    input  logic               fe_exception_valid,
    input  logic               fe_valid,
    input  logic               stall,
    input  logic               flush,
    output logic               fe_stall,
    output logic               de_valid,
    output logic [ADDR_W-1:0]  de_pc,
    output logic [6:0]         de_opcode,
    output logic [2:0]         de_funct3,
    output logic               de_funct7b5,
    output logic [4:0]         de_rs1,
    output logic [4:0]         de_rs2,
    output logic [4:0]         de_rd,
    output logic [31:0]        de_imm,
    output logic               de_reg_write,
    output logic               de_mem_read,
    output logic               de_mem_write,
    output logic               de_branch,
    output logic               de_jump,
    output logic               de_alu_src_imm,
    output logic [EX_W-1:0]    de_exception,
    output logic               de_exception_valid
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign instr  = fe_instr[31:0];
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Stall passes straight back to fetch, independent of reset and flush.
    assign fe_stall = stall;

    logic [4:0]      rs1_next;
    logic [4:0]      rs2_next;
    logic [4:0]      rd_next;
    logic [31:0]     imm_next;
    logic            reg_write_next;
    logic            mem_read_next;
    logic            mem_write_next;
    logic            branch_next;
    logic            jump_next;
    logic            alu_src_imm_next;
    logic            illegal;
    logic            exc_valid_next;
    logic [EX_W-1:0] exc_code_next;

    // Format decode: operand fields, immediate, raw control flags and legality.
    always_comb begin
        rs1_next         = instr[19:15];
        rs2_next         = instr[24:20];
        rd_next          = instr[11:7];
        imm_next         = '0;
        reg_write_next   = 1'b0;
        mem_read_next    = 1'b0;
        mem_write_next   = 1'b0;
        branch_next      = 1'b0;
        jump_next        = 1'b0;
        alu_src_imm_next = 1'b0;
        illegal          = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm_next         = {instr[31:12], 12'b0};
                rs1_next         = '0;
                rs2_next         = '0;
                reg_write_next   = 1'b1;
                alu_src_imm_next = 1'b1;
            end
            OP_JAL: begin
                imm_next         = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                rs1_next         = '0;
                rs2_next         = '0;
                reg_write_next   = 1'b1;
                jump_next        = 1'b1;
                alu_src_imm_next = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_IMM, OP_MISC, OP_SYSTEM: begin
                imm_next         = {{20{instr[31]}}, instr[31:20]};
                rs2_next         = '0;
                alu_src_imm_next = 1'b1;
                reg_write_next   = (opcode != OP_MISC) && (opcode != OP_SYSTEM);
                jump_next        = (opcode == OP_JALR);
                mem_read_next    = (opcode == OP_LOAD);
                if (opcode == OP_JALR)
                    illegal = (funct3 != 3'd0);
                else if (opcode == OP_LOAD)
                    illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
                else if (opcode == OP_IMM)
                    illegal = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                              ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
            end
            OP_STORE: begin
                imm_next         = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                rd_next          = '0;
                mem_write_next   = 1'b1;
                alu_src_imm_next = 1'b1;
                illegal          = (funct3 > 3'd2);
            end
            OP_BRANCH: begin
                imm_next    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                rd_next     = '0;
                branch_next = 1'b1;
                illegal     = (funct3 == 3'd2) || (funct3 == 3'd3);
            end
            OP_OP: begin
                reg_write_next = 1'b1;
                illegal        = ((funct7 != 7'h00) && (funct7 != 7'h20)) ||
                                 ((funct7 == 7'h20) && (funct3 != 3'd0) && (funct3 != 3'd5));
            end
            default: begin
                rs1_next = '0;
                rs2_next = '0;
                rd_next  = '0;
                illegal  = 1'b1;
            end
        endcase
        // Compressed or reserved low bits never match a 32-bit encoding.
        if (instr[1:0] != 2'b11)
            illegal = 1'b1;
    end

    // Exception selection: a fetch fault outranks an illegal encoding.
    always_comb begin
        exc_valid_next = fe_exception_valid || illegal;
        exc_code_next  = '0;
        if (fe_exception_valid)
            exc_code_next = fe_exception;
        else if (illegal)
            exc_code_next = EX_W'(EX_ILLEGAL);
    end

    // Pipeline register: reset > flush > stall > capture; excepting instructions have side effects suppressed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            de_valid           <= 1'b0;
            de_pc              <= '0;
            de_opcode          <= '0;
            de_funct3          <= '0;
            de_funct7b5        <= 1'b0;
            de_rs1             <= '0;
            de_rs2             <= '0;
            de_rd              <= '0;
            de_imm             <= '0;
            de_reg_write       <= 1'b0;
            de_mem_read        <= 1'b0;
            de_mem_write       <= 1'b0;
            de_branch          <= 1'b0;
            de_jump            <= 1'b0;
            de_alu_src_imm     <= 1'b0;
            de_exception       <= '0;
            de_exception_valid <= 1'b0;
        end else if (flush || (!stall && !fe_valid)) begin
            de_valid           <= 1'b0;
            de_reg_write       <= 1'b0;
            de_mem_read        <= 1'b0;
            de_mem_write       <= 1'b0;
            de_branch          <= 1'b0;
            de_jump            <= 1'b0;
            de_alu_src_imm     <= 1'b0;
            de_exception_valid <= 1'b0;
        end else if (!stall) begin
            de_valid           <= 1'b1;
            de_pc              <= fe_pc;
            de_opcode          <= opcode;
            de_funct3          <= funct3;
            de_funct7b5        <= instr[30];
            de_rs1             <= rs1_next;
            de_rs2             <= rs2_next;
            de_rd              <= rd_next;
            de_imm             <= imm_next;
            de_reg_write       <= reg_write_next && !exc_valid_next;
            de_mem_read        <= mem_read_next && !exc_valid_next;
            de_mem_write       <= mem_write_next && !exc_valid_next;
            de_branch          <= branch_next && !exc_valid_next;
            de_jump            <= jump_next && !exc_valid_next;
            de_alu_src_imm     <= alu_src_imm_next;
            de_exception       <= exc_code_next;
            de_exception_valid <= exc_valid_next;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Randomised scoreboard bench for the decode stage.
// The driver pushes the expected post-edge state into a queue; the monitor
// pops and compares on the falling edge after the target edge.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fe_instr = '0;
    logic [31:0] fe_pc = '0;
    logic [3:0]  fe_exception = '0;
    logic        fe_exception_valid = 1'b0;
    logic        fe_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        fe_stall;
    logic        de_valid;
    logic [31:0] de_pc;
    logic [6:0]  de_opcode;
    logic [2:0]  de_funct3;
    logic        de_funct7b5;
    logic [4:0]  de_rs1, de_rs2, de_rd;
    logic [31:0] de_imm;
    logic        de_reg_write, de_mem_read, de_mem_write, de_branch, de_jump, de_alu_src_imm;
    logic [3:0]  de_exception;
    logic        de_exception_valid;

    decode dut (
        .clk(clk), .reset(reset), .fe_instr(fe_instr), .fe_pc(fe_pc),
        .fe_exception(fe_exception), .fe_exception_valid(fe_exception_valid),
        .fe_valid(fe_valid), .stall(stall), .flush(flush), .fe_stall(fe_stall),
        .de_valid(de_valid), .de_pc(de_pc), .de_opcode(de_opcode), .de_funct3(de_funct3),
        .de_funct7b5(de_funct7b5), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd),
        .de_imm(de_imm), .de_reg_write(de_reg_write), .de_mem_read(de_mem_read),
        .de_mem_write(de_mem_write), .de_branch(de_branch), .de_jump(de_jump),
        .de_alu_src_imm(de_alu_src_imm), .de_exception(de_exception),
        .de_exception_valid(de_exception_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  f3;
        bit          f7b5;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        bit          rw, mr, mw, br, jp, asi, exv;
        logic [3:0]  ex;
        bit          c_fields, c_regs, c_exv, c_asi, c_ex;
        int          tgt;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   edge_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Sign-extend an n-bit unsigned field value using plain arithmetic.
    function automatic logic [31:0] sx(input int v, input int n);
        int r;
        r = v;
        if (r >= (1 << (n - 1))) r = r - (1 << n);
        return 32'(r);
    endfunction

    // Reference decode computed from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                        input bit fexv, input logic [3:0] fex);
        exp_t e;
        bit   ill;
        bit   known;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        e = '{default: 0};
        e.valid = 1; e.pc = pc; e.op = op; e.f3 = f3; e.f7b5 = i[30];
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = 0;
        known = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h33};
        ill = !known || (i[1:0] != 2'b11);
        if (op inside {7'h37, 7'h17}) begin
            e.imm = i & 32'hFFFF_F000; e.rs1 = 0; e.rs2 = 0;
        end else if (op == 7'h6F) begin
            e.imm = sx(int'(i[31]) * (1 << 20) + int'(i[19:12]) * (1 << 12) +
                       int'(i[20]) * (1 << 11) + int'(i[30:21]) * 2, 21);
            e.rs1 = 0; e.rs2 = 0;
        end else if (op inside {7'h67, 7'h03, 7'h13, 7'h0F, 7'h73}) begin
            e.imm = sx(int'(i[31:20]), 12); e.rs2 = 0;
        end else if (op == 7'h23) begin
            e.imm = sx(int'(f7) * 32 + int'(i[11:7]), 12); e.rd = 0;
        end else if (op == 7'h63) begin
            e.imm = sx(int'(i[31]) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 +
                       int'(i[11:8]) * 2, 13);
            e.rd = 0;
        end
        case (op)
            7'h67: ill = ill || (f3 != 0);
            7'h63: ill = ill || (f3 inside {3'd2, 3'd3});
            7'h03: ill = ill || (f3 inside {3'd3, 3'd6, 3'd7});
            7'h23: ill = ill || (f3 > 2);
            7'h13: ill = ill || (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20);
            7'h33: ill = ill || (f7 != 0 && f7 != 7'h20) || (f7 == 7'h20 && f3 != 0 && f3 != 5);
            default: ;
        endcase
        e.rw  = op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33};
        e.mr  = (op == 7'h03);
        e.mw  = (op == 7'h23);
        e.br  = (op == 7'h63);
        e.jp  = op inside {7'h6F, 7'h67};
        e.asi = known && !(op inside {7'h33, 7'h63});
        e.exv = fexv || ill;
        e.ex  = fexv ? fex : (ill ? 4'd2 : 4'd0);
        if (e.exv) begin
            e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0;
        end
        e.c_fields = 1; e.c_regs = known; e.c_asi = known; e.c_exv = 1; e.c_ex = e.exv;
        return e;
    endfunction

    // Drive one cycle of stimulus and queue the expected state after the next edge.
    task automatic step(input bit rst_n, input bit fl, input bit st, input bit fv,
                        input logic [31:0] instr, input logic [31:0] pc,
                        input bit fexv, input logic [3:0] fex);
        @(negedge clk);
        reset = rst_n; flush = fl; stall = st; fe_valid = fv;
        fe_instr = instr; fe_pc = pc; fe_exception_valid = fexv; fe_exception = fex;
        if (!rst_n) begin
            cur = '{default: 0};
            cur.c_fields = 1; cur.c_regs = 1; cur.c_exv = 1; cur.c_asi = 1; cur.c_ex = 1;
        end else if (fl || (!st && !fv)) begin
            cur.valid = 0; cur.rw = 0; cur.mr = 0; cur.mw = 0; cur.br = 0; cur.jp = 0;
            cur.asi = 0; cur.exv = 0;
            cur.c_fields = 0; cur.c_regs = 0; cur.c_asi = 1; cur.c_ex = 0;
            cur.c_exv = fl;
        end else if (!st) begin
            cur = ref_decode(instr, pc, fexv, fex);
        end
        cur.tgt = edge_cnt + 1;
        q.push_back(cur);
        #1;
        chk("fe_stall", 32'(fe_stall), 32'(st));
    endtask

    // Monitor: compare every queued expectation once its edge has happened.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tgt <= edge_cnt) begin
                e = q.pop_front();
                $display("edge %0d: valid=%0b pc=%h op=%h rd=%0d imm=%h exv=%0b ex=%0d",
                         e.tgt, de_valid, de_pc, de_opcode, de_rd, de_imm, de_exception_valid, de_exception);
                chk("valid", 32'(de_valid), 32'(e.valid));
                chk("reg_write", 32'(de_reg_write), 32'(e.rw));
                chk("mem_read", 32'(de_mem_read), 32'(e.mr));
                chk("mem_write", 32'(de_mem_write), 32'(e.mw));
                chk("branch", 32'(de_branch), 32'(e.br));
                chk("jump", 32'(de_jump), 32'(e.jp));
                if (e.c_asi) chk("alu_src_imm", 32'(de_alu_src_imm), 32'(e.asi));
                if (e.c_exv) chk("exc_valid", 32'(de_exception_valid), 32'(e.exv));
                if (e.c_ex) chk("exc_code", 32'(de_exception), 32'(e.ex));
                if (e.c_fields) begin
                    chk("pc", de_pc, e.pc);
                    chk("opcode", 32'(de_opcode), 32'(e.op));
                    chk("funct3", 32'(de_funct3), 32'(e.f3));
                    chk("funct7b5", 32'(de_funct7b5), 32'(e.f7b5));
                end
                if (e.c_regs) begin
                    chk("rs1", 32'(de_rs1), 32'(e.rs1));
                    chk("rs2", 32'(de_rs2), 32'(e.rs2));
                    chk("rd", 32'(de_rd), 32'(e.rd));
                    chk("imm", de_imm, e.imm);
                end
            end
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h33};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 7) == 0) return r;
        r[6:0] = ops[$urandom_range(0, 10)];
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            default: ;
        endcase
        return r;
    endfunction

    // Directed scenarios first, then a randomised stream.
    initial begin
        step(0, 0, 0, 0, 32'h0, 32'h0, 0, 4'd0);
        step(0, 0, 0, 0, 32'h0, 32'h0, 0, 4'd0);
        step(1, 0, 0, 1, 32'h0050_0093, 32'h0000_1000, 0, 4'd0);
        @(posedge clk); #2;
        chk("addi_imm", de_imm, 32'd5);
        chk("addi_rd", 32'(de_rd), 32'd1);
        step(1, 0, 0, 1, 32'h0020_A423, 32'h0000_1004, 0, 4'd0);
        step(1, 0, 0, 1, 32'hFE00_0EE3, 32'h0000_1008, 0, 4'd0);
        @(posedge clk); #2;
        chk("beq_imm", de_imm, 32'hFFFF_FFFC);
        step(1, 0, 0, 1, 32'hFFFF_FFFF, 32'h0000_100C, 0, 4'd0);
        step(1, 0, 0, 1, 32'h0050_0093, 32'h0000_1010, 1, 4'd0);
        step(1, 0, 0, 1, 32'h1234_52B7, 32'h0000_1014, 0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 1, 1, 32'h0000_0013, 32'h0000_1018, 0, 4'd0);
            @(posedge clk); #2;
            chk("lui_hold_imm", de_imm, 32'h1234_5000);
            chk("lui_hold_rd", 32'(de_rd), 32'd5);
        end
        step(1, 1, 1, 1, 32'h0000_0013, 32'h0000_1018, 0, 4'd0);
        @(posedge clk); #2;
        chk("flush_valid", 32'(de_valid), 32'd0);
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0,
                 rand_instr(), $urandom, $urandom_range(0, 9) == 0, 4'($urandom));
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
